// File: rtl/ram_burst_reader.sv
// Burst reader for the dual-port RAM wrapper: issues sequential reads on one port and
// returns the words as a valid/ready stream, with a credit-limited skid FIFO absorbing read latency.
module ram_burst_reader #(
  parameter int ASIZE      = 12,
  parameter int DSIZE      = 36,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [ASIZE:0]   start_len,
  output logic             busy,
  output logic             done,
  output logic [ASIZE-1:0] ram_addr,
  output logic             ram_we,
  input  logic [DSIZE-1:0] ram_dout,
  output logic [DSIZE-1:0] axis_tdata,
  output logic             axis_tvalid,
  input  logic             axis_tready,
  output logic             axis_tlast
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [ASIZE:0] LEN_ONE = (ASIZE + 1)'(1);

  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
    $error("ram_burst_reader: FIFO_DEPTH must be at least RD_LAT+1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state_q;
  logic [ASIZE-1:0]  next_addr_q;
  logic [ASIZE-1:0]  ram_addr_q;
  logic [ASIZE:0]    issue_left_q;
  logic [ASIZE:0]    beats_left_q;
  logic              issue_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT-1:0] pipe_d;
  logic [DSIZE-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [CW-1:0]     inflight;
  logic              busy_q;
  logic              done_q;
  logic              issue;
  logic              cap;
  logic              pop;
  logic              head_vld;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // issue_q marks the address currently on ram_addr; pipe_q tracks it until ram_dout is valid
  always_comb begin
    inflight = CW'(issue_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_q[i]);
    end
    pipe_d    = '0;
    pipe_d[0] = issue_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign head_vld = (count_q != '0);
  assign pop      = head_vld && axis_tready;
  assign cap      = pipe_q[RD_LAT-1];
  assign issue    = (state_q == ISSUE) && ((count_q + inflight) < CW'(FIFO_DEPTH));
  assign count_d  = count_q + CW'(cap) - CW'(pop);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      ram_addr_q   <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      issue_q      <= 1'b0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      issue_q <= issue;
      pipe_q  <= pipe_d;
      count_q <= count_d;
      done_q  <= 1'b0;
      if (cap) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q     <= ptr_inc(rd_ptr_q);
        beats_left_q <= beats_left_q - LEN_ONE;
      end
      if (issue) begin
        ram_addr_q   <= next_addr_q;
        next_addr_q  <= next_addr_q + 1'b1;
        issue_left_q <= issue_left_q - LEN_ONE;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_len != '0) begin
              next_addr_q  <= start_addr;
              issue_left_q <= start_len;
              beats_left_q <= start_len;
              busy_q       <= 1'b1;
              state_q      <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        ISSUE: begin
          if (issue && (issue_left_q == LEN_ONE)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && (beats_left_q == LEN_ONE)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage is datapath only; occupancy and pointers carry the reset
  always_ff @(posedge clock) begin
    if (cap) mem_q[wr_ptr_q] <= ram_dout;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      assert (!(cap && !pop && (count_q == CW'(FIFO_DEPTH))));
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = 1'b0;
  assign axis_tvalid = head_vld;
  assign axis_tdata  = head_vld ? mem_q[rd_ptr_q] : '0;
  assign axis_tlast  = head_vld && (beats_left_q == LEN_ONE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model holding word = address behind an RD_LAT pipeline.
module tb_ram_burst_reader;

  localparam int ASIZE      = 12;
  localparam int DSIZE      = 36;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 8;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [ASIZE-1:0] start_addr = '0;
  logic [ASIZE:0]   start_len = '0;
  logic             busy;
  logic             done;
  logic [ASIZE-1:0] ram_addr;
  logic             ram_we;
  logic [DSIZE-1:0] ram_dout;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tvalid;
  logic             axis_tready = 1'b1;
  logic             axis_tlast;

  int checks = 0;
  int errors = 0;

  ram_burst_reader #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .busy(busy), .done(done), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_dout(ram_dout), .axis_tdata(axis_tdata),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast)
  );

  always #5 clock = ~clock;

  // RAM with word = address and a fixed RD_LAT read latency
  logic [ASIZE-1:0] rp [RD_LAT];
  always @(posedge clock) begin
    rp[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign ram_dout = DSIZE'(rp[RD_LAT-1]);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [DSIZE:0]   beat_q [$];
  int               beat_cyc [$];
  int               done_cnt = 0;
  int               done_cyc = 0;
  int               vld_cnt = 0;
  int               issues = 0;
  int               pops = 0;
  int               max_out = 0;
  logic [ASIZE-1:0] prev_addr = '0;

  always @(negedge clock) begin
    if (!rst) begin
      if (ram_addr != prev_addr) issues = issues + 1;
      prev_addr = ram_addr;
      if (issues - pops > max_out) max_out = issues - pops;
      if (axis_tvalid) vld_cnt = vld_cnt + 1;
      if (axis_tvalid && axis_tready) begin
        beat_q.push_back({axis_tlast, axis_tdata});
        beat_cyc.push_back(cyc);
        pops = pops + 1;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    beat_q.delete();
    beat_cyc.delete();
    done_cnt = 0;
    vld_cnt  = 0;
    issues   = 0;
    pops     = 0;
    max_out  = 0;
  endtask

  task automatic do_start(input logic [ASIZE-1:0] a, input logic [ASIZE:0] l);
    @(posedge clock); #1;
    start = 1'b1; start_addr = a; start_len = l;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
      axis_tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
    axis_tready = 1'b1;
    check("done_seen", longint'(done_cnt != 0), 1);
  endtask

  task automatic check_beats(input int base, input int n, input string tag);
    int bad = 0;
    int lasts = 0;
    int m;
    check({tag, "_count"}, beat_q.size(), n);
    m = (beat_q.size() < n) ? beat_q.size() : n;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (beat_q[i][DSIZE]) lasts++;
      if (i < m && beat_q[i][DSIZE-1:0] !== DSIZE'((base + i) % (1 << ASIZE))) bad++;
    end
    check({tag, "_order"}, bad, 0);
    check({tag, "_tlast_cnt"}, lasts, 1);
    if (m > 0) check({tag, "_tlast_pos"}, beat_q[m-1][DSIZE], 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_tvalid"}, axis_tvalid, 0);
    check({tag, "_tlast"}, axis_tlast, 0);
    check({tag, "_tdata"}, axis_tdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int v0;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("rst");
    rst = 1'b0;

    // basic burst, no backpressure
    clr();
    do_start(12'h010, 13'd4);
    check("t1_busy", busy, 1);
    k = 0;
    while (!axis_tvalid && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("t1_first_lat", k, RD_LAT + 2);
    wait_done(100, 1'b0);
    check_beats(12'h010, 4, "t1");
    if (beat_cyc.size() == 4) begin
      check("t1_back2back", beat_cyc[3] - beat_cyc[0], 3);
      check("t1_done_lat", done_cyc - beat_cyc[3], 1);
    end
    @(posedge clock); #1;
    check("t1_busy_end", busy, 0);

    // random backpressure, credit limit reached
    clr();
    do_start(12'h000, 13'd64);
    wait_done(3000, 1'b1);
    check_beats(0, 64, "t2");
    check("t2_max_outstanding", max_out, FIFO_DEPTH);

    // address wrap
    clr();
    do_start(12'hFFE, 13'd4);
    wait_done(100, 1'b0);
    check_beats(12'hFFE, 4, "t3");

    // zero-length burst
    clr();
    do_start(12'h000, 13'd0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 1);
    @(posedge clock); #1;
    check("t4_done_clr", done, 0);
    repeat (10) @(posedge clock);
    #1;
    check("t4_no_tvalid", vld_cnt, 0);
    check("t4_done_cnt", done_cnt, 1);

    // full address-space burst
    clr();
    do_start(12'h005, 13'd4096);
    wait_done(6000, 1'b0);
    check_beats(12'h005, 4096, "t4b");

    // start pulse mid-burst is ignored
    clr();
    do_start(12'h020, 13'd8);
    repeat (3) @(posedge clock);
    do_start(12'h100, 13'd2);
    wait_done(100, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    check("t5_done_cnt", done_cnt, 1);
    check_beats(12'h020, 8, "t5");

    // reset mid-burst
    clr();
    do_start(12'h080, 13'd16);
    k = 0;
    while (beat_q.size() < 3 && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    check_idle_outputs("t6_rst");
    v0 = vld_cnt;
    repeat (30) @(posedge clock);
    #1;
    check("t6_beats", beat_q.size(), 3);
    check("t6_done_cnt", done_cnt, 0);
    check("t6_no_tvalid", vld_cnt - v0, 0);
    clr();
    do_start(12'h040, 13'd2);
    wait_done(100, 1'b0);
    check_beats(12'h040, 2, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
